// File: rtl/i2c_fifo_port_arbiter_if.sv
// Bus bundle between the FIFO port arbiter and its neighbours: host push port,
// engine fetch port, the FIFO's shared command port, status and FSM debug state.
interface i2c_fifo_port_arbiter_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    // Handshakes: host_wr_req and tx_req are single-cycle request pulses with
    // no ready; host_busy reports an unissued push (a push while busy is lost and
    // flagged in ovf_err), tx_valid is a single-cycle data pulse, and fifo_en is
    // a single-cycle command strobe qualifying fifo_rd_wr/fifo_din.
    logic             host_wr_req;
    logic [DW-1:0]    host_wdata;
    logic             host_busy;
    logic             tx_req;
    logic [DW-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_nodata;
    logic             fifo_rd_wr;
    logic             fifo_en;
    logic [DW-1:0]    fifo_din;
    logic [DW-1:0]    fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic             ovf_err;
    logic [CNT_W-1:0] tx_count;
    logic [1:0]       dbg_state;

    // Arbiter side.
    modport master (
        input  host_wr_req, host_wdata, tx_req, fifo_dout, fifo_empty, fifo_full,
        output host_busy, tx_data, tx_valid, tx_nodata, fifo_rd_wr, fifo_en,
        output fifo_din, ovf_err, tx_count, dbg_state
    );

    // Environment side: host regs, FIFO and byte engine.
    modport slave (
        output host_wr_req, host_wdata, tx_req, fifo_dout, fifo_empty, fifo_full,
        input  host_busy, tx_data, tx_valid, tx_nodata, fifo_rd_wr, fifo_en,
        input  fifo_din, ovf_err, tx_count, dbg_state
    );
endinterface

// File: rtl/i2c_fifo_port_arbiter.sv
// Round-robin scheduler for the byte FIFO's single rd_wr/en port, shared by host
// pushes and I2C engine pops. Requests are latched and issued as 1-cycle commands.
module i2c_fifo_port_arbiter #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    i2c_fifo_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD      = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    typedef enum logic {
        G_READ  = 1'b0,
        G_WRITE = 1'b1
    } grant_t;

    state_t           state_q,      state_d;
    grant_t           last_grant_q, last_grant_d;
    logic             wr_pend_q,    wr_pend_d;
    logic             rd_pend_q,    rd_pend_d;
    logic [DW-1:0]    wdata_q,      wdata_d;
    logic             fifo_en_q,    fifo_en_d;
    logic             fifo_rd_wr_q, fifo_rd_wr_d;
    logic [DW-1:0]    fifo_din_q,   fifo_din_d;
    logic [DW-1:0]    tx_data_q,    tx_data_d;
    logic             tx_valid_q,   tx_valid_d;
    logic             tx_nodata_q,  tx_nodata_d;
    logic             ovf_err_q,    ovf_err_d;
    logic [CNT_W-1:0] tx_count_q,   tx_count_d;
    logic             wr_elig;
    logic             rd_elig;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_pend_d    = wr_pend_q;
        rd_pend_d    = rd_pend_q;
        wdata_d      = wdata_q;
        fifo_en_d    = 1'b0;
        fifo_rd_wr_d = fifo_rd_wr_q;
        fifo_din_d   = fifo_din_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        ovf_err_d    = ovf_err_q;
        tx_count_d   = tx_count_q;

        // Flags seen in IDLE already reflect the previous command, since every
        // command is followed by at least one non-IDLE cycle.
        wr_elig = wr_pend_q && !bus.fifo_full;
        rd_elig = rd_pend_q && !bus.fifo_empty;

        case (state_q)
            S_IDLE: begin
                if (wr_elig && (!rd_elig || last_grant_q == G_READ)) begin
                    state_d      = S_WR;
                    fifo_en_d    = 1'b1;
                    fifo_rd_wr_d = 1'b1;
                    fifo_din_d   = wdata_q;
                    last_grant_d = G_WRITE;
                end else if (rd_elig) begin
                    state_d      = S_RD;
                    fifo_en_d    = 1'b1;
                    fifo_rd_wr_d = 1'b0;
                    last_grant_d = G_READ;
                end
            end
            S_WR: begin
                state_d   = S_IDLE;
                wr_pend_d = 1'b0;
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                state_d    = S_IDLE;
                tx_data_d  = bus.fifo_dout;
                tx_valid_d = 1'b1;
                rd_pend_d  = 1'b0;
                tx_count_d = tx_count_q + CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A push that lands while the previous one is still unissued is lost.
        if (bus.host_wr_req) begin
            if (wr_pend_q) begin
                ovf_err_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wdata_d   = bus.host_wdata;
            end
        end

        if (bus.tx_req && !rd_pend_q) begin
            rd_pend_d = 1'b1;
        end

        // Starved read: pending, not in flight, and nothing in the FIFO.
        tx_nodata_d = rd_pend_d && bus.fifo_empty &&
                      (state_d != S_RD) && (state_d != S_RD_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_READ;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wdata_q      <= '0;
            fifo_en_q    <= 1'b0;
            fifo_rd_wr_q <= 1'b0;
            fifo_din_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_nodata_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
            tx_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            wdata_q      <= wdata_d;
            fifo_en_q    <= fifo_en_d;
            fifo_rd_wr_q <= fifo_rd_wr_d;
            fifo_din_q   <= fifo_din_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_nodata_q  <= tx_nodata_d;
            ovf_err_q    <= ovf_err_d;
            tx_count_q   <= tx_count_d;
        end
    end

    assign bus.host_busy  = wr_pend_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_nodata  = tx_nodata_q;
    assign bus.fifo_rd_wr = fifo_rd_wr_q;
    assign bus.fifo_en    = fifo_en_q;
    assign bus.fifo_din   = fifo_din_q;
    assign bus.ovf_err    = ovf_err_q;
    assign bus.tx_count   = tx_count_q;
    assign bus.dbg_state  = state_q;
endmodule
